// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned), result = {remainder, quotient}.
// Optional macro DIV_EARLY_OUT_EN: finish in two edges when |divisor| > |dividend|.
module div_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               start_i,
   input  logic               signed_i,
   input  logic [WIDTH-1:0]   opdata1_i,
   input  logic [WIDTH-1:0]   opdata2_i,
   input  logic               annul_i,
   output logic [2*WIDTH-1:0] result_o,
   output logic               ready_o
);
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StFree, StByZero, StOn, StEnd} state_e;

   state_e               state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]     dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
   logic                 sgn_q, sgn_d, dsign_q, dsign_d, qsign_q, qsign_d;
   logic [2*WIDTH-1:0]   result_q, result_d;

   logic [WIDTH-1:0]     mag1, mag2;
   logic [WIDTH:0]       trial;
   logic                 ge;
   logic [WIDTH-1:0]     step_rem, step_quo, rem_fin, quo_fin;
   logic                 take_early, early_now;

   function automatic logic [WIDTH-1:0] cneg(input logic [WIDTH-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   assign mag1 = cneg(opdata1_i, signed_i & opdata1_i[WIDTH-1]);
   assign mag2 = cneg(opdata2_i, signed_i & opdata2_i[WIDTH-1]);

   // dvd_q shifts out dividend bits at the top while quotient bits enter at the bottom
   assign trial    = {rem_q, dvd_q[WIDTH-1]};
   assign ge       = trial >= {1'b0, dvs_q};
   assign step_rem = WIDTH'(ge ? trial - {1'b0, dvs_q} : trial);
   assign step_quo = {dvd_q[WIDTH-2:0], ge};

`ifdef DIV_EARLY_OUT_EN
   logic early_q, early_d;
   assign take_early = mag2 > mag1;
   assign early_now  = early_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) early_q <= 1'b0;
      else         early_q <= early_d;
   end
`else
   assign take_early = 1'b0;
   assign early_now  = 1'b0;
`endif

   // Early-out keeps the dividend magnitude in dvd_q; the sign fix-up restores the original value
   assign quo_fin = early_now ? '0 : step_quo;
   assign rem_fin = early_now ? dvd_q : step_rem;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q  <= StFree;
         cnt_q    <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         sgn_q    <= 1'b0;
         dsign_q  <= 1'b0;
         qsign_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         sgn_q    <= sgn_d;
         dsign_q  <= dsign_d;
         qsign_q  <= qsign_d;
         result_q <= result_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      sgn_d    = sgn_q;
      dsign_d  = dsign_q;
      qsign_d  = qsign_q;
      result_d = result_q;
`ifdef DIV_EARLY_OUT_EN
      early_d  = early_q;
`endif
      unique case (state_q)
         StFree: begin
            if (start_i && !annul_i) begin
               if (opdata2_i == '0) begin
                  state_d = StByZero;
               end else begin
                  state_d = StOn;
                  dvd_d   = mag1;
                  dvs_d   = mag2;
                  rem_d   = '0;
                  cnt_d   = '0;
                  sgn_d   = signed_i;
                  dsign_d = opdata1_i[WIDTH-1];
                  qsign_d = opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1];
`ifdef DIV_EARLY_OUT_EN
                  early_d = take_early;
`endif
               end
            end
         end
         StByZero: begin
            state_d  = StEnd;
            result_d = '0;
         end
         StOn: begin
            if (annul_i) begin
               state_d = StFree;
            end else if (early_now || cnt_q == CntW'(WIDTH - 1)) begin
               state_d  = StEnd;
               cnt_d    = cnt_q + 1'b1;
               result_d = {cneg(rem_fin, sgn_q & dsign_q), cneg(quo_fin, sgn_q & qsign_q)};
            end else begin
               rem_d = step_rem;
               dvd_d = step_quo;
               cnt_d = cnt_q + 1'b1;
            end
         end
         StEnd: begin
            if (annul_i || !start_i) state_d = StFree;
         end
         default: state_d = StFree;
      endcase
   end

   always_comb begin
      ready_o  = (state_q == StEnd);
      result_o = result_q;
   end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: vector table plus annul and asynchronous-reset sequences.
module tb_div_iter;
   logic        clk = 1'b0;
   logic        resetn;
   logic        start_i, signed_i, annul_i;
   logic [31:0] opdata1_i, opdata2_i;
   logic [63:0] result_o;
   logic        ready_o;

   int n_tests = 0;
   int n_fail  = 0;

`ifdef DIV_EARLY_OUT_EN
   localparam int LatEo = 2;
`else
   localparam int LatEo = 33;
`endif

   typedef struct {
      logic        sg;
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] res;
      int          lat;
   } vec_t;

   vec_t vecs[12];

   div_iter #(.WIDTH(32)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .start_i   (start_i),
      .signed_i  (signed_i),
      .opdata1_i (opdata1_i),
      .opdata2_i (opdata2_i),
      .annul_i   (annul_i),
      .result_o  (result_o),
      .ready_o   (ready_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int n;
      logic [63:0] held;
      n = 0;
      signed_i  = v.sg;
      opdata1_i = v.a;
      opdata2_i = v.b;
      start_i   = 1'b1;
      do begin
         @(posedge clk); #1;
         n++;
      end while (!ready_o && n < 100);
      chk($sformatf("latency[%0d]", idx), 64'(n), 64'(v.lat));
      chk($sformatf("result[%0d]", idx), result_o, v.res);
      held = v.res;
      // start held in END: new operands must be ignored, result stable
      opdata1_i = 32'h0000_0063;
      opdata2_i = 32'h0000_0005;
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("end_hold_ready[%0d]", idx), 64'(ready_o), 64'd1);
      chk($sformatf("end_hold_result[%0d]", idx), result_o, held);
      start_i = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("ready_drop[%0d]", idx), 64'(ready_o), 64'd0);
      chk($sformatf("result_keep[%0d]", idx), result_o, held);
   endtask

   initial begin
      int   seen_ready;
      vec_t v;
      vecs[0]  = '{1'b0, 32'd100,        32'd7,        {32'd2,        32'd14},       33};
      vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,        {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33};
      vecs[2]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,        {32'h0,        32'hFFFF_FFFF}, 33};
      vecs[3]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {32'h0,       32'h8000_0000}, 33};
      vecs[4]  = '{1'b1, 32'd7,          32'hFFFF_FFFE, {32'd1,       32'hFFFF_FFFD}, 33};
      vecs[5]  = '{1'b0, 32'h0000_1234,  32'd0,        {32'h0,        32'h0},         2};
      vecs[6]  = '{1'b0, 32'd5,          32'd9,        {32'd5,        32'd0},         LatEo};
      vecs[7]  = '{1'b1, 32'hFFFF_FFFB,  32'd9,        {32'hFFFF_FFFB, 32'd0},        LatEo};
      vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'd14},      33};
      vecs[9]  = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {32'h8000_0000, 32'd0},       LatEo};
      vecs[10] = '{1'b1, 32'h8000_0000,  32'd3,        {32'hFFFF_FFFE, 32'hD555_5556}, 33};
      vecs[11] = '{1'b0, 32'd9,          32'd3,        {32'd0,        32'd3},         33};

      resetn = 1'b0; start_i = 1'b0; signed_i = 1'b0; annul_i = 1'b0;
      opdata1_i = '0; opdata2_i = '0;
      #12;
      chk("reset_ready", 64'(ready_o), 64'd0);
      chk("reset_result", result_o, 64'd0);
      resetn = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

      // Annul at step 10: no result, ready never rises
      signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7; start_i = 1'b1;
      repeat (11) @(posedge clk);
      #1;
      annul_i = 1'b1; start_i = 1'b0;
      @(posedge clk); #1;
      annul_i = 1'b0;
      seen_ready = 0;
      for (int c = 0; c < 40; c++) begin
         if (ready_o) seen_ready = 1;
         @(posedge clk); #1;
      end
      chk("annul_no_ready", 64'(seen_ready), 64'd0);
      chk("annul_result_kept", result_o, {32'd0, 32'd3});
      v = '{1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33};
      run_vec(100, v);

      // Leave a nonzero result, then reset asynchronously mid-division
      v = '{1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33};
      run_vec(101, v);
      opdata1_i = 32'd1000; opdata2_i = 32'd7; start_i = 1'b1;
      repeat (21) @(posedge clk);
      #3;
      resetn = 1'b0;
      #1;
      chk("async_reset_ready", 64'(ready_o), 64'd0);
      chk("async_reset_result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      @(posedge clk); #1;
      v = '{1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, LatEo};
      run_vec(102, v);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
